microsequencer_car: RTL

//  Control-address register (CAR) sequencer for the microprogrammed control unit.

---
 rtl/microsequencer_car.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/microsequencer_car.sv
// Control-address register (CAR) sequencer for the microprogrammed control unit.
// Each posedge, the next control-store address is chosen from one of four
// sources: opcode encoder, constant RESET_ADDR, control-register jump, or
// CAR+1. Sequencing stalls on memory ops until moc. Halt freezes the CAR
// until the next reset.
// Optional feature macro: MICRO_STACK_EN adds a return-address stack with the
// ports call, ret and stack_err.
module microsequencer_car #(
  parameter int unsigned             ADDR_W      = 6,
  parameter logic [ADDR_W-1:0]       RESET_ADDR  = 'd1,
  parameter int unsigned             STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] enc_addr,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic              mem_req,
  input  logic              moc,
  input  logic              halt,
`ifdef MICRO_STACK_EN
  input  logic              call,
  input  logic              ret,
  output logic              stack_err,
`endif
  output logic [ADDR_W-1:0] car,
  output logic              car_valid,
  output logic              stall,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_WAIT  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t            cur_state, next_state;
  logic [ADDR_W-1:0] car_d;
  logic [ADDR_W-1:0] car_inc;
  logic [ADDR_W-1:0] sel_addr;
  logic              advance;
  logic              run_advance;

  assign car_inc   = car + ADDR_W'(1);
  assign state     = cur_state;
  assign car_valid = (cur_state != S_RESET);

  // Next-address source mux, driven by sel
  always_comb begin
    sel_addr = car_inc;
    unique case (sel)
      2'b00: sel_addr = enc_addr;
      2'b01: sel_addr = RESET_ADDR;
      2'b10: sel_addr = cr_addr;
      2'b11: sel_addr = car_inc;
    endcase
  end

  // FSM next state, advance strobe and stall (stall asserts in the same cycle the memory op is seen)
  always_comb begin
    next_state  = cur_state;
    advance     = 1'b0;
    run_advance = 1'b0;
    stall       = 1'b0;
    unique case (cur_state)
      S_RESET: next_state = S_RUN;
      S_RUN: begin
        if (halt) begin
          next_state = S_HALT;
        end else if (mem_req && !moc) begin
          next_state = S_WAIT;
          stall      = 1'b1;
        end else begin
          advance     = 1'b1;
          run_advance = 1'b1;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (moc) begin
          next_state = S_RUN;
          advance    = 1'b1;
        end
      end
      S_HALT: next_state = S_HALT;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_RESET;
    else        cur_state <= next_state;
  end

`ifdef MICRO_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stk [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              do_push, do_pop, stk_full, stk_empty, err_set;
  logic [IDX_W-1:0]  push_idx, pop_idx;

  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign push_idx  = IDX_W'(sp);
  assign pop_idx   = IDX_W'(sp - SP_W'(1));

  // Call/ret only act when RUN is advancing; ret wins over a simultaneous call
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = 1'b0;
    car_d   = car;
    if (advance) car_d = sel_addr;
    if (run_advance) begin
      if (ret) begin
        do_pop  = !stk_empty;
        err_set = call || stk_empty;
        car_d   = stk_empty ? RESET_ADDR : stk[pop_idx];
      end else if (call) begin
        do_push = !stk_full;
        err_set = stk_full;
      end
    end
  end

  // Return-address LIFO storage, pointer and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else begin
      if (err_set) stack_err <= 1'b1;
      if (do_push) begin
        stk[push_idx] <= car_inc;
        sp            <= sp + SP_W'(1);
      end else if (do_pop) begin
        sp <= sp - SP_W'(1);
      end
    end
  end
`else
  // Next CAR value: load selected address only when advancing
  always_comb begin
    car_d = car;
    if (advance) car_d = sel_addr;
  end
`endif

  // Control-address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) car <= RESET_ADDR;
    else        car <= car_d;
  end

endmodule
